// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer bank: the per-channel state
// encoding and the default parameter values used by the top level.
package timer_pkg;

  // Channel life cycle: IDLE -> RUN -> EXPIRED, with cancel/start able to leave any state.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } ch_state_t;

  localparam int unsigned DEF_NUM_CH    = 4;
  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_ONE_SEC   = 60;
  localparam int unsigned DEF_WARN_TIME = 10;

endpackage

// File: rtl/sec_prescaler.sv
// Divides the vsync rate down to one tick per second. The counter walks
// 0..ONE_SEC-1 while enabled and freezes while disabled, so pausing never
// loses or adds a tick. tick is a decode of the count register gated by
// enable, so it is only high in cycles where the count will actually wrap.
module sec_prescaler #(
  parameter int unsigned ONE_SEC = 60
) (
  input  logic vsync,
  input  logic restart,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (ONE_SEC > 1) ? $clog2(ONE_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(ONE_SEC - 1);

  logic [CW-1:0] cnt;

  // Free-running modulo-ONE_SEC counter, held while enable is low.
  always_ff @(posedge vsync) begin
    if (restart) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = enable && !restart && (cnt == LAST);

endmodule

// File: rtl/countdown_timer_bank.sv
// Bank of NUM_CH independent seconds countdown timers sharing one prescaler.
// Optional feature: define TIMER_WARN_EN to add the ch_warn output (channel
// running with time_left <= WARN_TIME); without it the port and logic vanish.
//
// Control strobes (ch_start, ch_cancel, ch_add) are single-cycle requests
// sampled on the rising vsync edge; there is no back-pressure. Per channel the
// winner in one cycle is cancel, then start (only when load_val is nonzero),
// then add combined with the second tick. The channel state register is
// g_ch[i].state for anyone probing the FSM.
module countdown_timer_bank
  import timer_pkg::*;
#(
  parameter int unsigned NUM_CH    = DEF_NUM_CH,
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned ONE_SEC   = DEF_ONE_SEC,
  parameter int unsigned WARN_TIME = DEF_WARN_TIME
) (
  input  logic                    vsync,
  input  logic                    restart,
  input  logic                    timer_go,
  input  logic [NUM_CH-1:0]       ch_start,
  input  logic [NUM_CH-1:0]       ch_cancel,
  input  logic [NUM_CH-1:0]       ch_add,
  input  logic [WIDTH-1:0]        load_val,
  input  logic [WIDTH-1:0]        add_val,
  output logic [NUM_CH*WIDTH-1:0] time_left,
  output logic [NUM_CH-1:0]       ch_active,
  output logic [NUM_CH-1:0]       ch_expired,
`ifdef TIMER_WARN_EN
  output logic [NUM_CH-1:0]       ch_warn,
`endif
  output logic                    sec_tick
);

  logic tick;

  sec_prescaler #(
    .ONE_SEC (ONE_SEC)
  ) u_prescaler (
    .vsync   (vsync),
    .restart (restart),
    .enable  (timer_go),
    .tick    (tick)
  );

  assign sec_tick = tick;

`ifndef TIMER_WARN_EN
  // A threshold beyond the counter range would be meaningless; this empty
  // elaboration branch only anchors WARN_TIME when the warning is not built.
  if (WARN_TIME > 2**WIDTH - 1) begin : g_warn_out_of_range
  end
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_t        state;
    logic [WIDTH-1:0] count;
    logic             expired_q;
    logic [WIDTH-1:0] add_term;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sat_sum;
    logic [WIDTH-1:0] next_run;

    // Running-state next count: saturating bonus add, then the second tick.
    always_comb begin
      add_term = ch_add[i] ? add_val : '0;
      sum      = {1'b0, count} + {1'b0, add_term};
      sat_sum  = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
      next_run = tick ? (sat_sum - WIDTH'(1)) : sat_sum;
    end

    // Channel FSM with registered count and one-cycle expiry pulse.
    always_ff @(posedge vsync) begin
      if (restart) begin
        state     <= IDLE;
        count     <= '0;
        expired_q <= 1'b0;
      end else begin
        expired_q <= 1'b0;
        if (ch_cancel[i]) begin
          state <= IDLE;
          count <= '0;
        end else if (ch_start[i] && (load_val != '0)) begin
          state <= RUN;
          count <= load_val;
        end else if (state == RUN) begin
          count <= next_run;
          if (tick && (next_run == '0)) begin
            state     <= EXPIRED;
            expired_q <= 1'b1;
          end
        end
      end
    end

    assign time_left[i*WIDTH +: WIDTH] = count;
    assign ch_active[i]                = (state == RUN);
    assign ch_expired[i]               = expired_q;
`ifdef TIMER_WARN_EN
    assign ch_warn[i] = (state == RUN) && (32'(count) <= WARN_TIME);
`endif
  end

endmodule

// File: tb/tb_countdown_timer_bank.sv
// Self-checking bench for countdown_timer_bank (ONE_SEC=10, WIDTH=8,
// NUM_CH=4, WARN_TIME=3). Define TIMER_WARN_EN to also exercise ch_warn.
module tb_countdown_timer_bank;

  localparam int NCH  = 4;
  localparam int W    = 8;
  localparam int OSEC = 10;
  localparam int WARN = 3;
  localparam int EW   = 45; // {warn[4], tick, expired[4], active[4], time_left[32]}

  logic              vsync;
  logic              restart;
  logic              timer_go;
  logic [NCH-1:0]    ch_start;
  logic [NCH-1:0]    ch_cancel;
  logic [NCH-1:0]    ch_add;
  logic [W-1:0]      load_val;
  logic [W-1:0]      add_val;
  logic [NCH*W-1:0]  time_left;
  logic [NCH-1:0]    ch_active;
  logic [NCH-1:0]    ch_expired;
  logic              sec_tick;
`ifdef TIMER_WARN_EN
  logic [NCH-1:0]    ch_warn;
`endif

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] exp_q[$];

  // Reference model state
  int m_pc;
  int m_tl[NCH];
  int m_st[NCH]; // 0 idle, 1 run, 2 expired
  bit m_ex[NCH];

  countdown_timer_bank #(
    .NUM_CH    (NCH),
    .WIDTH     (W),
    .ONE_SEC   (OSEC),
    .WARN_TIME (WARN)
  ) dut (
    .vsync      (vsync),
    .restart    (restart),
    .timer_go   (timer_go),
    .ch_start   (ch_start),
    .ch_cancel  (ch_cancel),
    .ch_add     (ch_add),
    .load_val   (load_val),
    .add_val    (add_val),
    .time_left  (time_left),
    .ch_active  (ch_active),
    .ch_expired (ch_expired),
`ifdef TIMER_WARN_EN
    .ch_warn    (ch_warn),
`endif
    .sec_tick   (sec_tick)
  );

  // Clock
  initial vsync = 1'b0;
  always #5 vsync = ~vsync;

  function automatic void check(string name, logic [63:0] actual, logic [63:0] want);
    checks++;
    if (actual !== want) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, actual, want);
    end
  endfunction

  // Spec model: advance one vsync edge using the inputs currently driven.
  task automatic model_update(output logic [EW-1:0] e);
    bit tk;
    int v;
    tk = !restart && timer_go && (m_pc == OSEC - 1);
    if (restart) begin
      m_pc = 0;
      for (int c = 0; c < NCH; c++) begin
        m_tl[c] = 0; m_st[c] = 0; m_ex[c] = 0;
      end
    end else begin
      if (timer_go) m_pc = (m_pc == OSEC - 1) ? 0 : m_pc + 1;
      for (int c = 0; c < NCH; c++) begin
        m_ex[c] = 0;
        if (ch_cancel[c]) begin
          m_st[c] = 0; m_tl[c] = 0;
        end else if (ch_start[c] && load_val != 0) begin
          m_st[c] = 1; m_tl[c] = int'(load_val);
        end else if (m_st[c] == 1) begin
          v = m_tl[c] + (ch_add[c] ? int'(add_val) : 0);
          if (v > 255) v = 255;
          if (tk) v = v - 1;
          m_tl[c] = v;
          if (tk && v == 0) begin
            m_st[c] = 2; m_ex[c] = 1;
          end
        end
      end
    end
    e = '0;
    for (int c = 0; c < NCH; c++) begin
      e[c*W +: W] = m_tl[c][7:0];
      e[32 + c]   = (m_st[c] == 1);
      e[36 + c]   = m_ex[c];
      e[41 + c]   = (m_st[c] == 1) && (m_tl[c] <= WARN);
    end
    e[40] = !restart && timer_go && (m_pc == OSEC - 1);
  endtask

  // Driver + scoreboard: push the expectation, clock, then pop and compare.
  task automatic step();
    logic [EW-1:0] e;
    model_update(e);
    exp_q.push_back(e);
    @(posedge vsync);
    #1;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      e = exp_q.pop_front();
      check("time_left",  64'(time_left),  64'(e[31:0]));
      check("ch_active",  64'(ch_active),  64'(e[35:32]));
      check("ch_expired", 64'(ch_expired), 64'(e[39:36]));
      check("sec_tick",   64'(sec_tick),   64'(e[40]));
`ifdef TIMER_WARN_EN
      check("ch_warn",    64'(ch_warn),    64'(e[44:41]));
`endif
    end
  endtask

  task automatic idle_inputs();
    ch_start = '0; ch_cancel = '0; ch_add = '0;
  endtask

  typedef struct {
    logic [NCH-1:0] start;
    logic [NCH-1:0] cancel;
    logic [NCH-1:0] add;
    logic [W-1:0]   load;
    logic [W-1:0]   addv;
    int             ch;
    logic [W-1:0]   want_tl;
    logic           want_act;
  } vec_t;

  function automatic vec_t mk(logic [3:0] s, logic [3:0] c, logic [3:0] a,
                              logic [7:0] l, logic [7:0] av, int ch,
                              logic [7:0] tl, logic act);
    vec_t v;
    v.start = s; v.cancel = c; v.add = a; v.load = l; v.addv = av;
    v.ch = ch; v.want_tl = tl; v.want_act = act;
    return v;
  endfunction

  vec_t vecs[11];

  initial begin
    int n;
    int pulses;
    logic [W-1:0] tl_seen;

    vecs[0]  = mk(4'b0010, 4'b0000, 4'b0000, 8'd100, 8'd0,   1, 8'd100, 1'b1);
    vecs[1]  = mk(4'b0000, 4'b0000, 4'b0010, 8'd0,   8'd200, 1, 8'd255, 1'b1);
    vecs[2]  = mk(4'b0000, 4'b0000, 4'b0010, 8'd0,   8'd1,   1, 8'd255, 1'b1);
    vecs[3]  = mk(4'b0100, 4'b0100, 4'b0000, 8'd50,  8'd0,   2, 8'd0,   1'b0);
    vecs[4]  = mk(4'b1000, 4'b0000, 4'b0000, 8'd7,   8'd0,   3, 8'd7,   1'b1);
    vecs[5]  = mk(4'b1000, 4'b0000, 4'b0000, 8'd20,  8'd0,   3, 8'd20,  1'b1);
    vecs[6]  = mk(4'b0001, 4'b0000, 4'b0000, 8'd0,   8'd0,   0, 8'd0,   1'b0);
    vecs[7]  = mk(4'b0000, 4'b1000, 4'b0000, 8'd0,   8'd0,   3, 8'd0,   1'b0);
    vecs[8]  = mk(4'b0000, 4'b0000, 4'b1000, 8'd0,   8'd5,   3, 8'd0,   1'b0);
    vecs[9]  = mk(4'b0000, 4'b0010, 4'b0000, 8'd0,   8'd0,   1, 8'd0,   1'b0);
    vecs[10] = mk(4'b0100, 4'b0000, 4'b0100, 8'd9,   8'd3,   2, 8'd9,   1'b1);

    restart = 1'b1; timer_go = 1'b1; idle_inputs();
    load_val = '0; add_val = '0;
    m_pc = 0;
    for (int c = 0; c < NCH; c++) begin
      m_tl[c] = 0; m_st[c] = 0; m_ex[c] = 0;
    end

    // Reset state
    step();
    check("reset_time_left", 64'(time_left), 64'd0);
    check("reset_active",    64'(ch_active), 64'd0);
    check("reset_expired",   64'(ch_expired), 64'd0);
    check("reset_sec_tick",  64'(sec_tick),  64'd0);

    // Countdown from 5 with a 50-cycle pause in the middle
    restart = 1'b0; ch_start = 4'b0001; load_val = 8'd5;
    step();
    check("load5_tl", 64'(time_left[7:0]), 64'd5);
    idle_inputs();
    for (int k = 0; k < 24; k++) step();
    check("pre_pause_tl", 64'(time_left[7:0]), 64'd3);
    timer_go = 1'b0;
    for (int k = 0; k < 50; k++) step();
    check("paused_tl", 64'(time_left[7:0]), 64'd3);
    timer_go = 1'b1;
    n = 0;
    while (ch_expired[0] !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check("resume_cycles_to_expiry", 64'(n), 64'd25);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (ch_expired[0] === 1'b1) pulses++;
    end
    check("expiry_pulse_single", 64'(pulses), 64'd0);
    check("expired_hold_tl", 64'(time_left[7:0]), 64'd0);
    check("expired_inactive", 64'(ch_active[0]), 64'd0);

    // Table of single-cycle strobe vectors with the prescaler frozen
    timer_go = 1'b0;
    for (int i = 0; i < 11; i++) begin
      ch_start = vecs[i].start; ch_cancel = vecs[i].cancel; ch_add = vecs[i].add;
      load_val = vecs[i].load;  add_val = vecs[i].addv;
      step();
      check($sformatf("vec%0d_tl", i), 64'(time_left[vecs[i].ch*W +: W]), 64'(vecs[i].want_tl));
      check($sformatf("vec%0d_act", i), 64'(ch_active[vecs[i].ch]), 64'(vecs[i].want_act));
    end
    idle_inputs();

    // Bonus add landing on the same edge as a second tick
    ch_start = 4'b0010; load_val = 8'd10;
    step();
    check("add_tick_load", 64'(time_left[15:8]), 64'd10);
    idle_inputs();
    timer_go = 1'b1;
    n = 0;
    while (sec_tick !== 1'b1 && n < 2*OSEC) begin
      step();
      n++;
    end
    check("wait_sec_tick", 64'(sec_tick), 64'd1);
    ch_add = 4'b0010; add_val = 8'd5;
    step();
    check("add_with_tick_tl", 64'(time_left[15:8]), 64'd14);
    idle_inputs();

    // Restart while every channel runs
    ch_start = 4'b1111; load_val = 8'd50;
    step();
    idle_inputs();
    for (int k = 0; k < 15; k++) step();
    check("all_running", 64'(ch_active), 64'hf);
    restart = 1'b1; ch_add = 4'b1111; add_val = 8'd9;
    step();
    check("restart_tl",      64'(time_left), 64'd0);
    check("restart_active",  64'(ch_active), 64'd0);
    check("restart_expired", 64'(ch_expired), 64'd0);
    restart = 1'b0; idle_inputs();
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (ch_expired !== 4'b0000) pulses++;
    end
    check("post_restart_no_expiry", 64'(pulses), 64'd0);

`ifdef TIMER_WARN_EN
    // Warning window on a 5 second countdown
    ch_start = 4'b0001; load_val = 8'd5;
    step();
    idle_inputs();
    tl_seen = 8'hff;
    n = 0;
    while (ch_expired[0] !== 1'b1 && n < 80) begin
      step();
      if (ch_warn[0] === 1'b1 && tl_seen == 8'hff) tl_seen = time_left[7:0];
      n++;
    end
    check("warn_rise_tl", 64'(tl_seen), 64'd3);
    check("warn_fall_on_expiry", 64'(ch_warn[0]), 64'd0);
`else
    tl_seen = '0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
